// File: rtl/mem_access.sv
// Memory-access pipeline stage: byte/halfword/word loads and stores over a
// big-endian req/ack bus, with registered write-back results and stall request.
module mem_access #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid_i,
  input  logic [4:0]  ex_wd_i,
  input  logic        ex_wreg_i,
  input  logic [31:0] ex_wdata_i,
  input  logic [3:0]  ex_memop_i,
  input  logic [31:0] ex_memaddr_i,
  input  logic [31:0] ex_memdata_i,
  output logic        stallreq_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic        wb_valid_o,
  output logic [4:0]  wb_wd_o,
  output logic        wb_wreg_o,
  output logic [31:0] wb_wdata_o,
  output logic        excp_o,
  output logic [1:0]  excp_code_o,
  output logic [31:0] badaddr_o
);
  typedef enum logic {IDLE, BUSY} state_t;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_t      r_state, w_state_next;
  logic [CW-1:0] r_cnt;
  logic [3:0]  r_op;
  logic [4:0]  r_wd;
  logic        r_wreg, r_we;
  logic [31:0] r_addr, r_wdata;
  logic [3:0]  r_sel;
  logic        r_wb_valid, r_wb_wreg, r_excp;
  logic [4:0]  r_wb_wd;
  logic [31:0] r_wb_wdata, r_badaddr;
  logic [1:0]  r_excp_code;

  logic        w_ld, w_st, w_byte, w_half, w_word, w_misal, w_timeout, w_busy;
  logic [3:0]  w_sel;
  logic [31:0] w_sdata, w_ldata;
  logic [7:0]  w_lbyte;
  logic [15:0] w_lhalf;

  assign w_ld    = (ex_memop_i >= 4'd1) && (ex_memop_i <= 4'd5);
  assign w_st    = (ex_memop_i >= 4'd6) && (ex_memop_i <= 4'd8);
  assign w_byte  = (ex_memop_i == 4'd1) || (ex_memop_i == 4'd2) || (ex_memop_i == 4'd6);
  assign w_half  = (ex_memop_i == 4'd3) || (ex_memop_i == 4'd4) || (ex_memop_i == 4'd7);
  assign w_word  = (ex_memop_i == 4'd5) || (ex_memop_i == 4'd8);
  assign w_misal = (w_half && ex_memaddr_i[0]) || (w_word && (ex_memaddr_i[1:0] != 2'b00));

  // Big-endian: the lowest byte address maps to the most significant lane.
  always_comb begin
    w_sel   = 4'b1111;
    w_sdata = ex_memdata_i;
    if (w_byte) begin
      w_sel   = 4'b1000 >> ex_memaddr_i[1:0];
      w_sdata = {4{ex_memdata_i[7:0]}};
    end else if (w_half) begin
      w_sel   = ex_memaddr_i[1] ? 4'b0011 : 4'b1100;
      w_sdata = {2{ex_memdata_i[15:0]}};
    end
  end

  always_comb begin
    w_lbyte = 8'd0;
    case (r_addr[1:0])
      2'd0: w_lbyte = bus_rdata_i[31:24];
      2'd1: w_lbyte = bus_rdata_i[23:16];
      2'd2: w_lbyte = bus_rdata_i[15:8];
      default: w_lbyte = bus_rdata_i[7:0];
    endcase
    w_lhalf = r_addr[1] ? bus_rdata_i[15:0] : bus_rdata_i[31:16];
    case (r_op)
      4'd1: w_ldata = {{24{w_lbyte[7]}}, w_lbyte};
      4'd2: w_ldata = {24'd0, w_lbyte};
      4'd3: w_ldata = {{16{w_lhalf[15]}}, w_lhalf};
      4'd4: w_ldata = {16'd0, w_lhalf};
      default: w_ldata = bus_rdata_i;
    endcase
  end

  assign w_timeout = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT - 1)) && !bus_ack_i;
  assign w_busy    = (r_state == BUSY);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (ex_valid_i && (w_ld || w_st) && !w_misal) w_state_next = BUSY;
      BUSY: if (bus_ack_i || w_timeout) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_op        <= 4'd0;
      r_wd        <= 5'd0;
      r_wreg      <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_sel       <= 4'd0;
      r_wb_valid  <= 1'b0;
      r_wb_wd     <= 5'd0;
      r_wb_wreg   <= 1'b0;
      r_wb_wdata  <= 32'd0;
      r_excp      <= 1'b0;
      r_excp_code <= 2'd0;
      r_badaddr   <= 32'd0;
    end else begin
      r_state     <= w_state_next;
      r_wb_valid  <= 1'b0;
      r_wb_wd     <= 5'd0;
      r_wb_wreg   <= 1'b0;
      r_wb_wdata  <= 32'd0;
      r_excp      <= 1'b0;
      r_excp_code <= 2'd0;
      r_badaddr   <= 32'd0;
      if (!w_busy) begin
        r_cnt <= '0;
        if (ex_valid_i) begin
          if (!(w_ld || w_st)) begin
            r_wb_valid <= 1'b1;
            r_wb_wd    <= ex_wd_i;
            r_wb_wreg  <= ex_wreg_i;
            r_wb_wdata <= ex_wdata_i;
          end else if (w_misal) begin
            r_wb_valid  <= 1'b1;
            r_wb_wd     <= ex_wd_i;
            r_excp      <= 1'b1;
            r_excp_code <= w_ld ? 2'b01 : 2'b10;
            r_badaddr   <= ex_memaddr_i;
          end else begin
            r_op    <= ex_memop_i;
            r_wd    <= ex_wd_i;
            r_wreg  <= ex_wreg_i;
            r_we    <= w_st;
            r_addr  <= ex_memaddr_i;
            r_sel   <= w_sel;
            r_wdata <= w_sdata;
          end
        end
      end else if (bus_ack_i) begin
        r_wb_valid <= 1'b1;
        r_wb_wd    <= r_wd;
        r_wb_wreg  <= r_we ? 1'b0 : r_wreg;
        r_wb_wdata <= r_we ? 32'd0 : w_ldata;
      end else if (w_timeout) begin
        r_wb_valid  <= 1'b1;
        r_wb_wd     <= r_wd;
        r_excp      <= 1'b1;
        r_excp_code <= 2'b11;
        r_badaddr   <= r_addr;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Bus signals are gated by BUSY so reset drops them on the same edge as the state.
  assign stallreq_o  = w_busy;
  assign bus_req_o   = w_busy;
  assign bus_we_o    = w_busy & r_we;
  assign bus_addr_o  = w_busy ? {r_addr[31:2], 2'b00} : 32'd0;
  assign bus_sel_o   = w_busy ? r_sel : 4'd0;
  assign bus_wdata_o = w_busy ? r_wdata : 32'd0;
  assign wb_valid_o  = r_wb_valid;
  assign wb_wd_o     = r_wb_wd;
  assign wb_wreg_o   = r_wb_wreg;
  assign wb_wdata_o  = r_wb_wdata;
  assign excp_o      = r_excp;
  assign excp_code_o = r_excp_code;
  assign badaddr_o   = r_badaddr;
endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access (TIMEOUT=4): none/load/store,
// misaligned, timeout, ack-at-timeout and reset-while-busy scenarios.
module tb_mem_access;
  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid_i;
  logic [4:0]  ex_wd_i;
  logic        ex_wreg_i;
  logic [31:0] ex_wdata_i;
  logic [3:0]  ex_memop_i;
  logic [31:0] ex_memaddr_i;
  logic [31:0] ex_memdata_i;
  logic        stallreq_o, bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
  logic [3:0]  bus_sel_o;
  logic        bus_ack_i;
  logic        wb_valid_o, wb_wreg_o, excp_o;
  logic [4:0]  wb_wd_o;
  logic [31:0] wb_wdata_o, badaddr_o;
  logic [1:0]  excp_code_o;

  int total = 0;
  int bad = 0;
  int ncyc;

  always #5 clk = ~clk;

  mem_access #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .ex_valid_i(ex_valid_i), .ex_wd_i(ex_wd_i), .ex_wreg_i(ex_wreg_i),
    .ex_wdata_i(ex_wdata_i), .ex_memop_i(ex_memop_i),
    .ex_memaddr_i(ex_memaddr_i), .ex_memdata_i(ex_memdata_i),
    .stallreq_o(stallreq_o), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
    .bus_addr_o(bus_addr_o), .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o),
    .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i),
    .wb_valid_o(wb_valid_o), .wb_wd_o(wb_wd_o), .wb_wreg_o(wb_wreg_o),
    .wb_wdata_o(wb_wdata_o), .excp_o(excp_o), .excp_code_o(excp_code_o),
    .badaddr_o(badaddr_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [4:0] wd, input logic wreg,
                       input logic [31:0] wdata, input logic [31:0] addr, input logic [31:0] sdata);
    ex_valid_i = 1'b1; ex_memop_i = op; ex_wd_i = wd; ex_wreg_i = wreg;
    ex_wdata_i = wdata; ex_memaddr_i = addr; ex_memdata_i = sdata;
    tick();
    ex_valid_i = 1'b0;
  endtask

  // Called in the first BUSY cycle; acks on busy cycle waits+1, returns cycles stalled.
  task automatic run_bus(input int waits, input logic [31:0] rdata, output int n);
    n = 0;
    while (stallreq_o && n < 20) begin
      n++;
      if (n == waits + 1) begin
        bus_ack_i = 1'b1; bus_rdata_i = rdata;
      end
      tick();
      bus_ack_i = 1'b0; bus_rdata_i = 32'd0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ex_valid_i = 1'b0; ex_wd_i = 5'd0; ex_wreg_i = 1'b0; ex_wdata_i = 32'd0;
    ex_memop_i = 4'd0; ex_memaddr_i = 32'd0; ex_memdata_i = 32'd0;
    bus_rdata_i = 32'd0; bus_ack_i = 1'b0;
    tick(); tick();
    chk("rst_req", {31'd0, bus_req_o}, 32'd0);
    chk("rst_wbv", {31'd0, wb_valid_o}, 32'd0);
    chk("rst_stall", {31'd0, stallreq_o}, 32'd0);
    rst = 1'b0;
    tick();

    // NONE
    issue(4'd0, 5'd3, 1'b1, 32'h0000_00FF, 32'h0, 32'h0);
    chk("none_wbv", {31'd0, wb_valid_o}, 32'd1);
    chk("none_wd", {27'd0, wb_wd_o}, 32'd3);
    chk("none_wdata", wb_wdata_o, 32'h0000_00FF);
    chk("none_req", {31'd0, bus_req_o}, 32'd0);
    tick();
    chk("none_pulse", {31'd0, wb_valid_o}, 32'd0);
    $display("txn NONE done");

    // LB
    issue(4'd1, 5'd8, 1'b1, 32'h0, 32'h0000_1001, 32'h0);
    chk("lb_req", {31'd0, bus_req_o}, 32'd1);
    chk("lb_sel", {28'd0, bus_sel_o}, 32'b0100);
    chk("lb_addr", bus_addr_o, 32'h0000_1000);
    chk("lb_we", {31'd0, bus_we_o}, 32'd0);
    run_bus(2, 32'h12F4_5678, ncyc);
    chk("lb_stall", ncyc, 32'd3);
    chk("lb_wbv", {31'd0, wb_valid_o}, 32'd1);
    chk("lb_wdata", wb_wdata_o, 32'hFFFF_FFF4);
    chk("lb_wreg", {31'd0, wb_wreg_o}, 32'd1);
    $display("txn LB done");

    // LBU
    issue(4'd2, 5'd8, 1'b1, 32'h0, 32'h0000_1001, 32'h0);
    run_bus(2, 32'h12F4_5678, ncyc);
    chk("lbu_wdata", wb_wdata_o, 32'h0000_00F4);
    $display("txn LBU done");

    // LH / LHU
    issue(4'd3, 5'd9, 1'b1, 32'h0, 32'h0000_1002, 32'h0);
    chk("lh_sel", {28'd0, bus_sel_o}, 32'b0011);
    run_bus(0, 32'h12F4_8765, ncyc);
    chk("lh_wdata", wb_wdata_o, 32'hFFFF_8765);
    issue(4'd4, 5'd9, 1'b1, 32'h0, 32'h0000_1000, 32'h0);
    chk("lhu_sel", {28'd0, bus_sel_o}, 32'b1100);
    run_bus(0, 32'h12F4_8765, ncyc);
    chk("lhu_wdata", wb_wdata_o, 32'h0000_12F4);
    $display("txn LH/LHU done");

    // SH
    issue(4'd7, 5'd4, 1'b1, 32'h0, 32'h0000_2002, 32'h0000_ABCD);
    chk("sh_we", {31'd0, bus_we_o}, 32'd1);
    chk("sh_sel", {28'd0, bus_sel_o}, 32'b0011);
    chk("sh_wdata", bus_wdata_o, 32'hABCD_ABCD);
    chk("sh_addr", bus_addr_o, 32'h0000_2000);
    run_bus(0, 32'h0, ncyc);
    chk("sh_stall", ncyc, 32'd1);
    chk("sh_wbv", {31'd0, wb_valid_o}, 32'd1);
    chk("sh_wreg", {31'd0, wb_wreg_o}, 32'd0);
    chk("sh_wbdata", wb_wdata_o, 32'd0);
    $display("txn SH done");

    // Misaligned LW / SW
    issue(4'd5, 5'd6, 1'b1, 32'h0, 32'h0000_3002, 32'h0);
    chk("adel_req", {31'd0, bus_req_o}, 32'd0);
    chk("adel_excp", {31'd0, excp_o}, 32'd1);
    chk("adel_code", {30'd0, excp_code_o}, 32'd1);
    chk("adel_bad", badaddr_o, 32'h0000_3002);
    chk("adel_wbv", {31'd0, wb_valid_o}, 32'd1);
    chk("adel_wreg", {31'd0, wb_wreg_o}, 32'd0);
    tick();
    chk("adel_pulse", {31'd0, excp_o}, 32'd0);
    issue(4'd8, 5'd6, 1'b0, 32'h0, 32'h0000_3002, 32'h0);
    chk("ades_code", {30'd0, excp_code_o}, 32'd2);
    chk("ades_excp", {31'd0, excp_o}, 32'd1);
    $display("txn AdEL/AdES done");

    // Timeout
    issue(4'd5, 5'd5, 1'b1, 32'h0, 32'h0000_4000, 32'h0);
    run_bus(100, 32'h0, ncyc);
    chk("to_reqcyc", ncyc, 32'd4);
    chk("to_req", {31'd0, bus_req_o}, 32'd0);
    chk("to_excp", {31'd0, excp_o}, 32'd1);
    chk("to_code", {30'd0, excp_code_o}, 32'd3);
    chk("to_bad", badaddr_o, 32'h0000_4000);
    chk("to_wreg", {31'd0, wb_wreg_o}, 32'd0);
    tick();
    chk("to_pulse", {31'd0, excp_o}, 32'd0);
    $display("txn TIMEOUT done");

    // Ack on the timeout cycle
    issue(4'd5, 5'd5, 1'b1, 32'h0, 32'h0000_4004, 32'h0);
    run_bus(3, 32'hDEAD_BEEF, ncyc);
    chk("ackto_cyc", ncyc, 32'd4);
    chk("ackto_excp", {31'd0, excp_o}, 32'd0);
    chk("ackto_wdata", wb_wdata_o, 32'hDEAD_BEEF);
    chk("ackto_wreg", {31'd0, wb_wreg_o}, 32'd1);
    chk("ackto_wd", {27'd0, wb_wd_o}, 32'd5);
    $display("txn ACK@TIMEOUT done");

    // Reset while busy
    issue(4'd5, 5'd2, 1'b1, 32'h0, 32'h0000_5000, 32'h0);
    chk("rb_req", {31'd0, bus_req_o}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rb_req0", {31'd0, bus_req_o}, 32'd0);
    chk("rb_stall0", {31'd0, stallreq_o}, 32'd0);
    chk("rb_addr0", bus_addr_o, 32'd0);
    chk("rb_wbv0", {31'd0, wb_valid_o}, 32'd0);
    chk("rb_excp0", {31'd0, excp_o}, 32'd0);
    issue(4'd0, 5'd7, 1'b1, 32'h0000_1234, 32'h0, 32'h0);
    chk("rb_none_wbv", {31'd0, wb_valid_o}, 32'd1);
    chk("rb_none_wdata", wb_wdata_o, 32'h0000_1234);
    $display("txn RESET-BUSY done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
